pwm_duty_ramp: RTL and testbench

- Wishbone-slave soft-start/soft-stop stage that sits directly upstream of the PWM controller on the wireless car.
- Software writes a target duty per motor channel. The block slews each channel's output duty toward its target at a programmable rate, so motors never see step changes.
- Outputs per-channel current duty and enable, which drive the PWM stage's duty_cycle and enable inputs.

---
 rtl/pwm_ramp_pkg.sv | 36 +++
 rtl/pwm_ramp_channel.sv | 85 ++++++++
 rtl/pwm_duty_ramp.sv | 131 +++++++++++++
 tb/tb_pwm_duty_ramp.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ramp_pkg.sv
// Shared definitions for the PWM duty ramp block: register word offsets,
// field positions, the per-channel state encoding and a byte-lane merge helper.
package pwm_ramp_pkg;

    // Word indices decoded from byte address bits [9:2]
    localparam logic [7:0] CH0_TARGET_IDX = 8'h00;
    localparam logic [7:0] CH1_TARGET_IDX = 8'h01;
    localparam logic [7:0] CH2_TARGET_IDX = 8'h02;
    localparam logic [7:0] CH3_TARGET_IDX = 8'h03;
    localparam logic [7:0] RAMP_CFG_IDX   = 8'h04;
    localparam logic [7:0] STATUS_IDX     = 8'h05;
    localparam logic [7:0] DONE_IDX       = 8'h06;

    localparam int EN_BIT    = 31;
    localparam int STEP_LSB  = 16;
    localparam int STEP_BITS = 8;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_IDLE,
        ST_UP,
        ST_DOWN
    } ch_state_e;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_ramp_channel.sv
// One motor channel: slews its duty toward the target by STEP on each ramp
// tick, and snaps to zero the clock after its enable drops.
module pwm_ramp_channel
    import pwm_ramp_pkg::*;
#(
    parameter int DUTY_BITS = 8,
    parameter int STEP_W    = STEP_BITS
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RST_i,
    input  logic                 tick,
    input  logic [DUTY_BITS-1:0] target,
    input  logic                 en_req,
    input  logic [STEP_W-1:0]    step,
    output logic [DUTY_BITS-1:0] cur,
    output logic                 en,
    output logic                 busy,
    output logic                 done_pulse
);

    // One spare bit so cur + step can never wrap before clamping
    localparam int SUM_W = ((DUTY_BITS > STEP_W) ? DUTY_BITS : STEP_W) + 1;

    ch_state_e            state_q, state_nxt;
    logic [DUTY_BITS-1:0] cur_q, cur_nxt;
    logic                 en_q;
    logic [SUM_W-1:0]     cur_x, tgt_x, step_x, up_sum, dn_diff;
    logic [DUTY_BITS-1:0] up_val, dn_val;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        cur_x   = SUM_W'(cur_q);
        tgt_x   = SUM_W'(target);
        step_x  = SUM_W'(step);
        up_sum  = cur_x + step_x;
        dn_diff = cur_x - step_x;
        up_val  = (step == '0 || up_sum >= tgt_x) ? target : up_sum[DUTY_BITS-1:0];
        dn_val  = (step == '0 || cur_x < tgt_x + step_x) ? target : dn_diff[DUTY_BITS-1:0];

        state_nxt = state_q;
        cur_nxt   = cur_q;

        case (state_q)
            ST_OFF: begin
                cur_nxt = '0;
                if (en_req) state_nxt = ST_IDLE;
            end
            default: begin
                if (!en_req) begin
                    state_nxt = ST_OFF;
                    cur_nxt   = '0;
                end else begin
                    // Direction follows the live target so a mid-ramp change reverses cleanly
                    if (tick && (state_q == ST_UP || state_q == ST_DOWN)) begin
                        if (cur_q < target)      cur_nxt = up_val;
                        else if (cur_q > target) cur_nxt = dn_val;
                    end
                    if (cur_nxt < target)      state_nxt = ST_UP;
                    else if (cur_nxt > target) state_nxt = ST_DOWN;
                    else                       state_nxt = ST_IDLE;
                end
            end
        endcase

        done_pulse = (state_q == ST_UP || state_q == ST_DOWN) && (state_nxt == ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values together.
    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            state_q <= ST_OFF;
            cur_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cur_q   <= cur_nxt;
            en_q    <= (state_nxt != ST_OFF);
        end
    end

    assign cur  = cur_q;
    assign en   = en_q;
    assign busy = (state_q == ST_UP) || (state_q == ST_DOWN);

endmodule

// File: rtl/pwm_duty_ramp.sv
// Wishbone soft-start/soft-stop stage feeding the PWM controller.
// Define PWM_RAMP_DONE_IRQ_EN to add the DONE register and irq_o.
module pwm_duty_ramp
    import pwm_ramp_pkg::*;
#(
    parameter int          NUM_CH            = 4,
    parameter int          DUTY_BITS         = 8,
    parameter int          PRESCALE_BITS     = 16,
    parameter logic [31:0] DEFAULT_REG_VALUE = 32'hDEF_FAB_AC
) (
    input  logic                        WBs_CLK_i,
    input  logic                        WBs_RST_i,
    input  logic [16:0]                 WBs_ADR_i,
    input  logic                        WBs_CYC_i,
    input  logic                        WBs_STB_i,
    input  logic                        WBs_WE_i,
    input  logic [3:0]                  WBs_BYTE_STB_i,
    input  logic [31:0]                 WBs_DAT_i,
    output logic [31:0]                 WBs_DAT_o,
    output logic                        WBs_ACK_o,
    output logic [NUM_CH*DUTY_BITS-1:0] duty_o,
    output logic [NUM_CH-1:0]           en_o
`ifdef PWM_RAMP_DONE_IRQ_EN
    ,
    output logic                        irq_o
`endif
);

    localparam logic [31:0] CH_MASK  = (32'd1 << EN_BIT) | ((32'd1 << DUTY_BITS) - 32'd1);
    localparam logic [31:0] CFG_MASK = 32'h00FF_0000 | ((32'd1 << PRESCALE_BITS) - 32'd1);

    logic                     ack_q;
    logic                     wr_stb, cfg_wr, tick;
    logic [7:0]               reg_idx;
    logic [31:0]              cfg_q;
    logic [31:0]              ch_reg [NUM_CH];
    logic [PRESCALE_BITS-1:0] pre_cnt, prescale;
    logic [NUM_CH-1:0]        busy, done_pulse;
    logic [31:0]              rd_data;
    logic                     unused_adr;

    assign reg_idx    = WBs_ADR_i[9:2];
    assign unused_adr = ^{WBs_ADR_i[16:10], WBs_ADR_i[1:0]};
    assign wr_stb     = WBs_CYC_i & WBs_STB_i & WBs_WE_i & ~ack_q;
    assign cfg_wr     = wr_stb && (reg_idx == RAMP_CFG_IDX);
    assign prescale   = cfg_q[PRESCALE_BITS-1:0];

    // NOTE: the register file is a handful of flops, not a RAM, so it takes the async reset like any other state.
    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            ack_q <= 1'b0;
            cfg_q <= '0;
            for (int n = 0; n < NUM_CH; n++) ch_reg[n] <= '0;
        end else begin
            ack_q <= WBs_CYC_i & WBs_STB_i & ~ack_q;
            if (cfg_wr) cfg_q <= byte_merge(cfg_q, WBs_DAT_i, WBs_BYTE_STB_i) & CFG_MASK;
            for (int n = 0; n < NUM_CH; n++) begin
                if (wr_stb && reg_idx == CH0_TARGET_IDX + 8'(n))
                    ch_reg[n] <= byte_merge(ch_reg[n], WBs_DAT_i, WBs_BYTE_STB_i) & CH_MASK;
            end
        end
    end

    // A config write restarts the tick period and suppresses that cycle's tick
    assign tick = (pre_cnt == prescale) && !cfg_wr;

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i)                            pre_cnt <= '0;
        else if (cfg_wr || pre_cnt == prescale)   pre_cnt <= '0;
        else                                      pre_cnt <= pre_cnt + 1'b1;
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        pwm_ramp_channel #(
            .DUTY_BITS (DUTY_BITS),
            .STEP_W    (STEP_BITS)
        ) u_ch (
            .WBs_CLK_i  (WBs_CLK_i),
            .WBs_RST_i  (WBs_RST_i),
            .tick       (tick),
            .target     (ch_reg[n][DUTY_BITS-1:0]),
            .en_req     (ch_reg[n][EN_BIT]),
            .step       (cfg_q[STEP_LSB +: STEP_BITS]),
            .cur        (duty_o[n*DUTY_BITS +: DUTY_BITS]),
            .en         (en_o[n]),
            .busy       (busy[n]),
            .done_pulse (done_pulse[n])
        );
    end

`ifdef PWM_RAMP_DONE_IRQ_EN
    logic [NUM_CH-1:0] done_q, done_clr;

    assign done_clr = (wr_stb && reg_idx == DONE_IDX && WBs_BYTE_STB_i[0])
                      ? WBs_DAT_i[NUM_CH-1:0] : '0;

    // Set is OR-ed in after the clear so a same-cycle completion wins
    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            done_q <= '0;
            irq_o  <= 1'b0;
        end else begin
            done_q <= (done_q & ~done_clr) | done_pulse;
            irq_o  <= |done_q;
        end
    end
`else
    logic unused_done;
    assign unused_done = |done_pulse;
`endif

    always_comb begin
        rd_data = DEFAULT_REG_VALUE;
        case (reg_idx)
            RAMP_CFG_IDX: rd_data = cfg_q;
            STATUS_IDX:   rd_data = 32'(busy);
`ifdef PWM_RAMP_DONE_IRQ_EN
            DONE_IDX:     rd_data = 32'(done_q);
`endif
            default: begin
                for (int n = 0; n < NUM_CH; n++) begin
                    if (reg_idx == CH0_TARGET_IDX + 8'(n)) rd_data = ch_reg[n];
                end
            end
        endcase
    end

    assign WBs_DAT_o = rd_data;
    assign WBs_ACK_o = ack_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Self-checking bench for pwm_duty_ramp: register vector table, then ramp,
// clamp, disable, tick-coincidence, byte-lane, optional DONE/irq and reset cases.
module tb_pwm_duty_ramp;

    localparam logic [31:0] DEF_VAL = 32'hDEF_FAB_AC;
`ifdef PWM_RAMP_DONE_IRQ_EN
    localparam logic [31:0] DONE_RST = 32'h0;
`else
    localparam logic [31:0] DONE_RST = DEF_VAL;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [16:0] adr = '0;
    logic        cyc_i = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  be = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic        ack;
    logic [31:0] duty;
    logic [3:0]  en;
    logic        irq;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0]  exp_q [$];
    logic [31:0] rd_q  [$];
    int          chg_cyc [$];

    typedef struct {
        logic        we;
        logic [16:0] adr;
        logic [3:0]  be;
        logic [31:0] wdat;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [17];

    pwm_duty_ramp dut (
        .WBs_CLK_i      (clk),
        .WBs_RST_i      (rst),
        .WBs_ADR_i      (adr),
        .WBs_CYC_i      (cyc_i),
        .WBs_STB_i      (stb),
        .WBs_WE_i       (we),
        .WBs_BYTE_STB_i (be),
        .WBs_DAT_i      (dat_i),
        .WBs_DAT_o      (dat_o),
        .WBs_ACK_o      (ack),
        .duty_o         (duty),
        .en_o           (en)
`ifdef PWM_RAMP_DONE_IRQ_EN
        ,
        .irq_o          (irq)
`endif
    );

`ifndef PWM_RAMP_DONE_IRQ_EN
    assign irq = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] duty_of(input int ch);
        return duty[ch*8 +: 8];
    endfunction

    // Bus tasks start at a falling edge and return at a falling edge with ACK low
    task automatic wb_write(input logic [16:0] a, input logic [31:0] d, input logic [3:0] b);
        int n;
        adr = a; dat_i = d; be = b; we = 1'b1; cyc_i = 1'b1; stb = 1'b1;
        n = 0;
        @(posedge clk); #1; n++;
        while (!ack && n < 8) begin @(posedge clk); #1; n++; end
        check($sformatf("wr_ack@%h", a), {31'd0, ack}, 32'd1);
        cyc_i = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic wb_read(input logic [16:0] a, input logic [31:0] exp, input string name);
        int n;
        logic [31:0] e;
        rd_q.push_back(exp);
        adr = a; be = 4'hF; we = 1'b0; cyc_i = 1'b1; stb = 1'b1;
        n = 0;
        @(posedge clk); #1; n++;
        while (!ack && n < 8) begin @(posedge clk); #1; n++; end
        e = rd_q.pop_front();
        if (!ack) check({name, "_ack"}, {31'd0, ack}, 32'd1);
        else      check(name, dat_o, e);
        cyc_i = 1'b0; stb = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Pops one expected duty each time the channel's duty changes
    task automatic watch(input int ch, input int budget, input string name);
        logic [7:0] prev, now, e;
        int n;
        prev = duty_of(ch);
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
            now = duty_of(ch);
            if (now !== prev) begin
                e = exp_q.pop_front();
                check(name, {24'd0, now}, {24'd0, e});
                chg_cyc.push_back(cyc);
                prev = now;
            end
        end
        if (exp_q.size() > 0) begin
            check({name, "_timeout_left"}, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 17'h00000, 4'h0, 32'h0,         32'h0};
        vecs[1]  = '{1'b0, 17'h00004, 4'h0, 32'h0,         32'h0};
        vecs[2]  = '{1'b0, 17'h00008, 4'h0, 32'h0,         32'h0};
        vecs[3]  = '{1'b0, 17'h0000C, 4'h0, 32'h0,         32'h0};
        vecs[4]  = '{1'b0, 17'h00010, 4'h0, 32'h0,         32'h0};
        vecs[5]  = '{1'b0, 17'h00014, 4'h0, 32'h0,         32'h0};
        vecs[6]  = '{1'b0, 17'h00018, 4'h0, 32'h0,         DONE_RST};
        vecs[7]  = '{1'b0, 17'h00020, 4'h0, 32'h0,         DEF_VAL};
        vecs[8]  = '{1'b0, 17'h003FC, 4'h0, 32'h0,         DEF_VAL};
        vecs[9]  = '{1'b1, 17'h00004, 4'hF, 32'h7FFF_FFFF, 32'h0000_00FF};
        vecs[10] = '{1'b1, 17'h00004, 4'h1, 32'h0000_1234, 32'h0000_0034};
        vecs[11] = '{1'b1, 17'h00010, 4'hF, 32'hFFFF_FFFF, 32'h00FF_FFFF};
        vecs[12] = '{1'b1, 17'h00010, 4'h2, 32'h1234_5678, 32'h00FF_56FF};
        vecs[13] = '{1'b1, 17'h00014, 4'hF, 32'hFFFF_FFFF, 32'h0};
        vecs[14] = '{1'b1, 17'h00020, 4'hF, 32'h0000_0001, DEF_VAL};
        vecs[15] = '{1'b1, 17'h00004, 4'hF, 32'h0,         32'h0};
        vecs[16] = '{1'b1, 17'h00010, 4'hF, 32'h0,         32'h0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_duty", duty, 32'h0);
        check("rst_en", {28'd0, en}, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);

        for (int i = 0; i < 17; i++) begin
            if (vecs[i].we) wb_write(vecs[i].adr, vecs[i].wdat, vecs[i].be);
            wb_read(vecs[i].adr, vecs[i].exp, $sformatf("regvec[%0d]", i));
        end

        // CH0: tick every clock, step 0x10 up to 0x40
        wb_write(17'h10, 32'h0010_0000, 4'hF);
        wb_write(17'h00, 32'h8000_0040, 4'hF);
        exp_q.push_back(8'h10); exp_q.push_back(8'h20);
        exp_q.push_back(8'h30); exp_q.push_back(8'h40);
        watch(0, 30, "ch0_ramp");
        check("ch0_en", {31'd0, en[0]}, 32'd1);
        wb_read(17'h14, 32'h0, "ch0_status_idle");

        // CH1: jump to 0xE0, then clamp at 0xF0, then descend with underflow clamp
        wb_write(17'h10, 32'h0000_0000, 4'hF);
        wb_write(17'h04, 32'h8000_00E0, 4'hF);
        exp_q.push_back(8'hE0);
        watch(1, 20, "ch1_jump");
        wb_write(17'h10, 32'h0030_0003, 4'hF);
        wb_write(17'h04, 32'h8000_00F0, 4'hF);
        exp_q.push_back(8'hF0);
        watch(1, 30, "ch1_clamp_hi");
        repeat (12) @(negedge clk);
        check("ch1_no_overshoot", {24'd0, duty_of(1)}, 32'h0000_00F0);
        chg_cyc.delete();
        wb_write(17'h04, 32'h8000_0005, 4'hF);
        exp_q.push_back(8'hC0);
        watch(1, 30, "ch1_down");
        wb_read(17'h14, 32'h2, "ch1_status_busy");
        exp_q.push_back(8'h90); exp_q.push_back(8'h60);
        exp_q.push_back(8'h30); exp_q.push_back(8'h05);
        watch(1, 60, "ch1_down");
        check("ch1_change_count", chg_cyc.size(), 5);
        for (int i = 1; i < chg_cyc.size(); i++)
            check($sformatf("ch1_tick_spacing[%0d]", i), chg_cyc[i] - chg_cyc[i-1], 4);

        // CH2: disable mid-ramp, re-enable, then reverse mid-ramp
        wb_write(17'h10, 32'h0001_0003, 4'hF);
        wb_write(17'h08, 32'h8000_0080, 4'hF);
        repeat (40) @(negedge clk);
        check("ch2_progress", {31'd0, duty_of(2) != 8'h00}, 32'd1);
        wb_read(17'h14, 32'h4, "ch2_status_busy");
        adr = 17'h08; dat_i = 32'h0000_0080; be = 4'hF; we = 1'b1; cyc_i = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        check("ch2_dis_ack", {31'd0, ack}, 32'd1);
        check("ch2_dis_before", {31'd0, duty_of(2) != 8'h00}, 32'd1);
        check("ch2_dis_en_before", {31'd0, en[2]}, 32'd1);
        cyc_i = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        check("ch2_dis_duty", {24'd0, duty_of(2)}, 32'h0);
        check("ch2_dis_en", {31'd0, en[2]}, 32'd0);
        @(negedge clk);
        wb_read(17'h14, 32'h0, "ch2_status_off");
        wb_write(17'h08, 32'h8000_0080, 4'hF);
        exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
        watch(2, 40, "ch2_reramp");
        wb_write(17'h08, 32'h8000_0000, 4'hF);
        exp_q.push_back(8'h02); exp_q.push_back(8'h01); exp_q.push_back(8'h00);
        watch(2, 40, "ch2_reverse");

        // CH3: target write lands on a tick edge; the old target governs that tick
        wb_write(17'h10, 32'h0010_0003, 4'hF);
        wb_write(17'h0C, 32'h8000_0080, 4'hF);
        exp_q.push_back(8'h10); exp_q.push_back(8'h20);
        watch(3, 40, "ch3_ramp");
        repeat (3) @(negedge clk);
        wb_write(17'h0C, 32'h8000_0025, 4'hF);
        check("ch3_tick_old_target", {24'd0, duty_of(3)}, 32'h0000_0030);
        exp_q.push_back(8'h25);
        watch(3, 20, "ch3_new_target");

        // Top byte lane only: EN toggles, target is kept
        wb_write(17'h0C, 32'h0000_0000, 4'b1000);
        check("ch3_lane_off_duty", {24'd0, duty_of(3)}, 32'h0);
        check("ch3_lane_off_en", {31'd0, en[3]}, 32'd0);
        wb_read(17'h0C, 32'h0000_0025, "ch3_lane_off_reg");
`ifdef PWM_RAMP_DONE_IRQ_EN
        wb_write(17'h18, 32'h0000_000F, 4'hF);
        wb_read(17'h18, 32'h0, "done_cleared");
        check("irq_cleared", {31'd0, irq}, 32'd0);
`endif
        wb_write(17'h0C, 32'h8000_0000, 4'b1000);
        exp_q.push_back(8'h10); exp_q.push_back(8'h20);
        watch(3, 40, "ch3_lane_on");
        repeat (3) @(negedge clk);
`ifdef PWM_RAMP_DONE_IRQ_EN
        wb_write(17'h18, 32'h0000_0008, 4'hF);
`else
        repeat (2) @(negedge clk);
`endif
        check("ch3_lane_on_final", {24'd0, duty_of(3)}, 32'h0000_0025);
        wb_read(17'h0C, 32'h8000_0025, "ch3_lane_on_reg");
`ifdef PWM_RAMP_DONE_IRQ_EN
        wb_read(17'h18, 32'h8, "done_set_wins");
        check("irq_set", {31'd0, irq}, 32'd1);
        wb_write(17'h18, 32'h0000_0008, 4'hF);
        wb_read(17'h18, 32'h0, "done_w1c");
        check("irq_w1c", {31'd0, irq}, 32'd0);
`endif
        wb_read(17'h14, 32'h0, "all_idle_status");

        // Asynchronous reset in the middle of a ramp
        wb_write(17'h10, 32'h0001_0003, 4'hF);
        wb_write(17'h08, 32'h8000_00FF, 4'hF);
        repeat (20) @(negedge clk);
        check("rst_mid_progress", {31'd0, duty_of(2) != 8'h00}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_duty", duty, 32'h0);
        check("rst_mid_en", {28'd0, en}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wb_read(17'h08, 32'h0, "rst_mid_ch2_reg");
        wb_read(17'h14, 32'h0, "rst_mid_status");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
